// File: rtl/sa_psum_deskew.sv
// Re-aligns the skewed psum lanes leaving the bottom edge of a systolic array into whole rows.
// Each lane buffers its own elements; a row is handed off once every lane holds at least one entry.
module sa_psum_deskew #(
    parameter int PE_SIZE    = 4,
    parameter int PSUM_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
    input  logic [PE_SIZE-1:0]            psum_en_row_i,
    input  logic                          clear_i,
    input  logic                          row_ready_i,
    output logic [PSUM_WIDTH*PE_SIZE-1:0] row_o,
    output logic                          row_valid_o,
    output logic [PE_SIZE-1:0]            lane_full_o,
    output logic                          overflow_o,
    output logic [15:0]                   row_cnt_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [PE_SIZE-1:0] lane_nonempty;
    logic [PE_SIZE-1:0] lane_drop;
    logic               pop;

    // Row validity depends only on registered occupancy, never on this cycle's pushes or ready.
    assign row_valid_o = &lane_nonempty;
    assign pop         = row_valid_o & row_ready_i;

    for (genvar j = 0; j < PE_SIZE; j++) begin : g_lane
        logic [PSUM_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr;
        logic [PTR_W-1:0]      rd_ptr;
        logic [CNT_W-1:0]      cnt;
        logic                  en;
        logic                  full;
        logic                  push;

        assign en   = psum_en_row_i[PE_SIZE-1-j];
        assign full = (cnt == CNT_FULL);
        // A full lane still accepts a push when the same edge pops it.
        assign push = en & (~full | pop);

        assign lane_drop[j]               = en & full & ~pop;
        assign lane_nonempty[j]           = (cnt != '0);
        assign lane_full_o[PE_SIZE-1-j]   = full;
        assign row_o[PSUM_WIDTH*(PE_SIZE-j)-1 -: PSUM_WIDTH] = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= psum_row_i[PSUM_WIDTH*(PE_SIZE-j)-1 -: PSUM_WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else if (clear_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
            row_cnt_o  <= '0;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
            row_cnt_o  <= '0;
        end else begin
            if (|lane_drop) begin
                overflow_o <= 1'b1;
            end
            if (pop) begin
                row_cnt_o <= row_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sa_psum_deskew.sv
// Directed bench for sa_psum_deskew: skew alignment, back-pressure, overflow, full push+pop, clear, async reset.
module tb_sa_psum_deskew;

    localparam int PE = 4;
    localparam int W  = 32;
    localparam int D  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W*PE-1:0] psum_row_i;
    logic [PE-1:0]   psum_en_row_i;
    logic            clear_i;
    logic            row_ready_i;
    logic [W*PE-1:0] row_o;
    logic            row_valid_o;
    logic [PE-1:0]   lane_full_o;
    logic            overflow_o;
    logic [15:0]     row_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    sa_psum_deskew #(
        .PE_SIZE    (PE),
        .PSUM_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .psum_row_i    (psum_row_i),
        .psum_en_row_i (psum_en_row_i),
        .clear_i       (clear_i),
        .row_ready_i   (row_ready_i),
        .row_o         (row_o),
        .row_valid_o   (row_valid_o),
        .lane_full_o   (lane_full_o),
        .overflow_o    (overflow_o),
        .row_cnt_o     (row_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // Lane 0 occupies the most significant slice.
    function automatic logic [W*PE-1:0] mk_row(logic [31:0] a, logic [31:0] b,
                                               logic [31:0] c, logic [31:0] d);
        return {a, b, c, d};
    endfunction

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(logic [PE-1:0] en, logic [W*PE-1:0] d);
        psum_en_row_i = en;
        psum_row_i    = d;
    endtask

    task automatic clear_pulse();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    // One row skewed by one cycle per lane, ready held high.
    task automatic skew_row(int base, logic [15:0] cnt_before);
        row_ready_i = 1'b1;
        drive(4'b1000, mk_row(base + 1, 0, 0, 0)); step();
        check("skew_v0", 128'(row_valid_o), 0);
        drive(4'b0100, mk_row(0, base + 2, 0, 0)); step();
        check("skew_v1", 128'(row_valid_o), 0);
        drive(4'b0010, mk_row(0, 0, base + 3, 0)); step();
        check("skew_v2", 128'(row_valid_o), 0);
        drive(4'b0001, mk_row(0, 0, 0, base + 4)); step();
        check("skew_v3", 128'(row_valid_o), 1);
        check("skew_row", 128'(row_o), 128'(mk_row(base + 1, base + 2, base + 3, base + 4)));
        check("skew_cnt_pre", 128'(row_cnt_o), 128'(cnt_before));
        drive('0, '0); step();
        check("skew_v4", 128'(row_valid_o), 0);
        check("skew_cnt", 128'(row_cnt_o), 128'(cnt_before + 16'd1));
    endtask

    function automatic logic [W*PE-1:0] full_row(int k);
        return mk_row(1000 + 10 * k, 1001 + 10 * k, 1002 + 10 * k, 1003 + 10 * k);
    endfunction

    initial begin
        logic [W*PE-1:0] d;
        logic [PE-1:0]   en;
        int              r;

        rst_n = 1'b0;
        clear_i = 1'b0;
        row_ready_i = 1'b0;
        drive('0, '0);
        step();
        step();
        check("rst_valid", 128'(row_valid_o), 0);
        check("rst_cnt", 128'(row_cnt_o), 0);
        check("rst_full", 128'(lane_full_o), 0);
        check("rst_ovf", 128'(overflow_o), 0);
        rst_n = 1'b1;

        // Basic skewed row
        skew_row(0, 16'd0);

        // Back-pressure with three overlapping skewed rows
        row_ready_i = 1'b0;
        clear_pulse();
        check("bp_clr_cnt", 128'(row_cnt_o), 0);
        for (int t = 0; t < 6; t++) begin
            en = '0;
            d  = '0;
            for (int j = 0; j < PE; j++) begin
                r = t - j;
                if (r >= 0 && r < 3) begin
                    en[PE-1-j] = 1'b1;
                    d[W*(PE-j)-1 -: W] = 32'(100 * (r + 1) + j);
                end
            end
            drive(en, d);
            step();
            if (t == 2) check("bp_v_early", 128'(row_valid_o), 0);
            if (t >= 3) begin
                check("bp_v_hold", 128'(row_valid_o), 1);
                check("bp_row0", 128'(row_o), 128'(mk_row(100, 101, 102, 103)));
            end
        end
        drive('0, '0);
        step();
        step();
        check("bp_row0_stable", 128'(row_o), 128'(mk_row(100, 101, 102, 103)));
        check("bp_cnt_hold", 128'(row_cnt_o), 0);
        row_ready_i = 1'b1;
        for (int k = 1; k < 3; k++) begin
            step();
            check("bp_row", 128'(row_o), 128'(mk_row(100 * (k + 1), 100 * (k + 1) + 1,
                                                     100 * (k + 1) + 2, 100 * (k + 1) + 3)));
            check("bp_cnt", 128'(row_cnt_o), 128'(k));
        end
        step();
        check("bp_v_end", 128'(row_valid_o), 0);
        check("bp_cnt_end", 128'(row_cnt_o), 3);

        // Overflow on lane 0
        clear_pulse();
        for (int k = 1; k <= 9; k++) begin
            drive(4'b1000, mk_row(k, 0, 0, 0));
            step();
            if (k == 7) check("ovf_notfull7", 128'(lane_full_o), 0);
            if (k == 8) begin
                check("ovf_full8", 128'(lane_full_o), 4'b1000);
                check("ovf_none8", 128'(overflow_o), 0);
            end
        end
        check("ovf_set", 128'(overflow_o), 1);
        check("ovf_full9", 128'(lane_full_o), 4'b1000);
        check("ovf_v", 128'(row_valid_o), 0);
        for (int k = 0; k < 8; k++) begin
            drive(4'b0111, mk_row(0, 10 + k, 20 + k, 30 + k));
            step();
            check("ovf_row", 128'(row_o), 128'(mk_row(k + 1, 10 + k, 20 + k, 30 + k)));
        end
        drive('0, '0);
        step();
        check("ovf_drain_v", 128'(row_valid_o), 0);
        check("ovf_drain_full", 128'(lane_full_o), 0);
        check("ovf_sticky", 128'(overflow_o), 1);
        check("ovf_cnt", 128'(row_cnt_o), 8);

        // Full lanes, push and pop on the same edge
        row_ready_i = 1'b0;
        clear_pulse();
        check("fpp_clr_ovf", 128'(overflow_o), 0);
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, full_row(k));
            step();
        end
        check("fpp_full", 128'(lane_full_o), 4'b1111);
        row_ready_i = 1'b1;
        drive(4'b1111, full_row(8));
        step();
        drive('0, '0);
        check("fpp_ovf", 128'(overflow_o), 0);
        check("fpp_still_full", 128'(lane_full_o), 4'b1111);
        check("fpp_row1", 128'(row_o), 128'(full_row(1)));
        check("fpp_cnt1", 128'(row_cnt_o), 1);
        for (int k = 2; k <= 8; k++) begin
            step();
            check("fpp_drain", 128'(row_o), 128'(full_row(k)));
        end
        step();
        check("fpp_v_end", 128'(row_valid_o), 0);
        check("fpp_cnt_end", 128'(row_cnt_o), 9);

        // Clear with one complete row and two partial lanes pending
        row_ready_i = 1'b0;
        drive(4'b1111, mk_row(51, 52, 53, 54)); step();
        drive(4'b1100, mk_row(61, 62, 0, 0)); step();
        check("clr_pre_v", 128'(row_valid_o), 1);
        clear_i = 1'b1;
        row_ready_i = 1'b1;
        drive(4'b1111, mk_row(71, 72, 73, 74));
        step();
        clear_i = 1'b0;
        row_ready_i = 1'b0;
        drive('0, '0);
        check("clr_v", 128'(row_valid_o), 0);
        check("clr_cnt", 128'(row_cnt_o), 0);
        check("clr_ovf", 128'(overflow_o), 0);
        check("clr_full", 128'(lane_full_o), 0);
        drive(4'b1111, mk_row(81, 82, 83, 84)); step();
        drive('0, '0);
        check("clr_post_row", 128'(row_o), 128'(mk_row(81, 82, 83, 84)));
        row_ready_i = 1'b1;
        step();
        check("clr_post_v", 128'(row_valid_o), 0);
        check("clr_post_cnt", 128'(row_cnt_o), 1);

        // Asynchronous reset mid-operation
        row_ready_i = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            drive(4'b1000, mk_row(k, 0, 0, 0));
            step();
        end
        drive(4'b0100, mk_row(0, 77, 0, 0));
        check("ar_pre_full", 128'(lane_full_o), 4'b1000);
        check("ar_pre_ovf", 128'(overflow_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 128'(row_valid_o), 0);
        check("ar_full", 128'(lane_full_o), 0);
        check("ar_ovf", 128'(overflow_o), 0);
        check("ar_cnt", 128'(row_cnt_o), 0);
        drive('0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        skew_row(200, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_psum_deskew.md
SA_PSUM_DESKEW -- requirements
Module: sa_psum_deskew

Interface
REQ-001 Parameter PE_SIZE, default 4, number of psum lanes (SA columns).
REQ-002 Parameter PSUM_WIDTH, default 32, bits per psum lane.
REQ-003 Parameter FIFO_DEPTH, default 8, entries per lane FIFO; power of two, >= PE_SIZE.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 psum_row_i  input  PSUM_WIDTH*PE_SIZE  skewed psum lanes from SA bottom edge; lane j at bits [PSUM_WIDTH*(PE_SIZE-j)-1 -: PSUM_WIDTH].
REQ-007 psum_en_row_i  input  PE_SIZE  per-lane valid; lane j at bit PE_SIZE-1-j.
REQ-008 clear_i  input  1  synchronous flush of all state.
REQ-009 row_ready_i  input  1  downstream accepts row_o.
REQ-010 row_o  output  PSUM_WIDTH*PE_SIZE  aligned row, same lane packing as psum_row_i.
REQ-011 row_valid_o  output  1  row_o holds a complete aligned row.
REQ-012 lane_full_o  output  PE_SIZE  per-lane FIFO full, lane j at bit PE_SIZE-1-j.
REQ-013 overflow_o  output  1  sticky, a lane push was dropped.
REQ-014 row_cnt_o  output  16  rows handed off since reset/clear.

Function
REQ-015 Each lane SHALL own an independent FIFO of FIFO_DEPTH x PSUM_WIDTH with its own write pointer, read pointer and occupancy count (0..FIFO_DEPTH).
REQ-016 Lane push: psum_en bit of that lane high at a rising edge -> lane data written at write pointer, pointer increments modulo FIFO_DEPTH.
REQ-017 Arbitrary inter-lane skew SHALL be tolerated; the k-th element pushed into every lane forms row k, independent of arrival order across lanes.
REQ-018 row_valid_o SHALL be high iff every lane count > 0; derived from registered counts only, no combinational path from psum_en_row_i or row_ready_i.
REQ-019 row_o SHALL present each lane's head entry; valid in the cycle row_valid_o is high.
REQ-020 Handoff: row_valid_o and row_ready_i both high at an edge -> every lane pops once, row_cnt_o increments by 1 (wraps 0xFFFF->0).
REQ-021 row_o/row_valid_o SHALL hold stable while row_valid_o high and row_ready_i low.
REQ-022 Latency: last-missing lane element pushed at edge N -> row_valid_o high in cycle after edge N (1 cycle).
REQ-023 Push to a full lane without same-edge pop: data dropped, pointers/count unchanged, overflow_o set at that edge; other lanes unaffected.
REQ-024 Push and pop on same lane at same edge: both performed, count unchanged, no overflow even when full.
REQ-025 lane_full_o bit high iff that lane count == FIFO_DEPTH.
REQ-026 clear_i high at an edge: all counts and pointers to 0, overflow_o to 0, row_cnt_o to 0; same-edge pushes and pops discarded; clear has priority over all other events.
REQ-027 FIFO storage contents need not be reset; outputs derived from storage are qualified by row_valid_o.

Reset
REQ-028 rst_n low SHALL asynchronously force all counts and pointers to 0, row_valid_o 0, lane_full_o 0, overflow_o 0, row_cnt_o 0.
REQ-029 rst_n asserted mid-operation SHALL discard all buffered partial and complete rows; first row after release is formed only from post-reset pushes.
REQ-030 row_o value during/after reset is don't-care while row_valid_o is 0.

Verification
REQ-031 Skewed row, PE_SIZE=4: lanes 0..3 pushed 1,2,3,4 at edges 0,1,2,3, row_ready_i=1 -> row_valid_o high in cycle 4 only, row_o={1,2,3,4}, row_cnt_o=1.
REQ-032 Back-pressure: 3 skewed rows with row_ready_i=0 -> row_valid_o stays high with row 0 stable; raise ready -> rows 0,1,2 emitted on 3 consecutive edges, row_cnt_o=3.
REQ-033 Overflow: 9 pushes on lane 0 only, ready=1 -> lane_full_o[3] high after 8th, 9th dropped, overflow_o=1, later rows 0..7 carry values of pushes 1..8.
REQ-034 Full-lane push+pop: all lanes full, ready=1, push all lanes same edge -> counts stay 8, overflow_o remains 0.
REQ-035 clear_i asserted with 2 partial lanes and 1 complete row pending -> next cycle row_valid_o=0, counts 0, row_cnt_o=0, overflow_o=0.
REQ-036 rst_n pulsed low asynchronously mid-row -> outputs zero immediately; fresh skewed row afterwards aligns per REQ-031.
